// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI master byte engine; SPI_ARB_TIMEOUT_EN adds a WAIT watchdog
module spi_xfer_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              Clk_i,
  input  logic              Rst_ni,
  input  logic [NREQ-1:0]   Req_i,
  input  logic [NREQ*8-1:0] Data_i,
  input  logic [NREQ*2-1:0] Ss_i,
  output logic [NREQ-1:0]   Ack_o,
  output logic [NREQ-1:0]   Done_o,
  output logic [7:0]        Rdata_o,
  output logic              Err_o,
  output logic              Busy_o,
  output logic [7:0]        MBuf_o,
  output logic [1:0]        MSs_o,
  output logic              MStrobe_o,
  input  logic              MReady_i,
  input  logic [7:0]        MRcvd_i
);
  localparam int GW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, GAP} stateT;
  stateT state;
  logic [GW-1:0] grant, win, idx;
  logic found;
  logic [7:0] winData;
  logic [1:0] winSs;
  logic [3:0] gapCnt;
  logic readyPrev, readyRise;
  assign readyRise = MReady_i & ~readyPrev;
  assign winData = Data_i[{win, 3'b000} +: 8];
  assign winSs = Ss_i[{win, 1'b0} +: 2];
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmoCnt;
  logic tmoHit;
  assign tmoHit = tmoCnt == TW'(TIMEOUT_CYCLES - 1);
`else
  // the watchdog limit has no effect when the watchdog is not built
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif
  // round-robin winner: first requester at or after the one following the last grant
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = GW'((int'(grant) + i) % NREQ);
      if (!found && Req_i[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // arbiter FSM with registered master-side and requester-side outputs
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state <= IDLE;
      grant <= GW'(NREQ - 1);
      gapCnt <= '0;
      readyPrev <= 1'b0;
      Ack_o <= '0;
      Done_o <= '0;
      Rdata_o <= '0;
      Err_o <= 1'b0;
      Busy_o <= 1'b0;
      MBuf_o <= '0;
      MSs_o <= '0;
      MStrobe_o <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmoCnt <= '0;
`endif
    end else begin
      readyPrev <= MReady_i;
      Ack_o <= '0;
      Done_o <= '0;
      Err_o <= 1'b0;
      MStrobe_o <= 1'b0;
      case (state)
        IDLE: if (found) begin
          grant <= win;
          MBuf_o <= winData;
          MSs_o <= winSs;
          Ack_o <= NREQ'(1) << win;
          Busy_o <= 1'b1;
          if (^winSs) begin
            MStrobe_o <= 1'b1;
            state <= STROBE;
          end else begin
            Done_o <= NREQ'(1) << win;
            Err_o <= 1'b1;
            gapCnt <= '0;
            state <= GAP;
          end
        end
        STROBE: begin
          state <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          tmoCnt <= '0;
`endif
        end
        WAIT: begin
          if (readyRise) begin
            Rdata_o <= MRcvd_i;
            Done_o <= NREQ'(1) << grant;
            gapCnt <= '0;
            state <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmoHit) begin
            Rdata_o <= 8'hFF;
            Done_o <= NREQ'(1) << grant;
            Err_o <= 1'b1;
            gapCnt <= '0;
            state <= GAP;
          end else tmoCnt <= tmoCnt + 1'b1;
`endif
        end
        GAP: if (gapCnt == 4'(GAP_CYCLES)) begin
          state <= IDLE;
          Busy_o <= 1'b0;
        end else gapCnt <= gapCnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
